// File: rtl/controlador_hd.sv
`default_nettype none
// ============================================================================
// Module   : controlador_hd
// Brief    : Word-by-word transfer engine between the per-context disk store
//            and main data memory (load = disk->mem, store = mem->disk).
// Revision : 1.0 - initial release
// ============================================================================
module controlador_hd #(
    parameter int HD_CONTEXTOS = 4,
    parameter int HD_PALAVRAS  = 51,
    parameter int MEM_PALAVRAS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic        operacao,
    input  logic [31:0] contexto,
    input  logic [31:0] hd_base,
    input  logic [31:0] mem_base,
    input  logic [31:0] quantidade,
    output logic [31:0] hd_endereco,
    output logic [31:0] hd_contexto,
    output logic [31:0] hd_dado_escrita,
    output logic        hd_escrita,
    input  logic [31:0] hd_dado_saida,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_dado_escrita,
    output logic        mem_escrita,
    input  logic [31:0] mem_dado_saida,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro
);

    localparam logic [31:0] C_CONTEXTOS = 32'(HD_CONTEXTOS);
    localparam logic [32:0] C_HD_LIMITE = 33'(HD_PALAVRAS);
    localparam logic [32:0] C_MEM_LIMITE = 33'(MEM_PALAVRAS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LER      = 3'd1,
        ESPERA   = 3'd2,
        ESCREVER = 3'd3,
        FIM      = 3'd4
    } estado_t;

    estado_t     r_estado;
    estado_t     w_proximo;
    logic        r_op;
    logic        r_rejeitado;
    logic [31:0] r_hd_base;
    logic [31:0] r_mem_base;
    logic [31:0] r_quantidade;
    logic [31:0] r_i;
    logic [31:0] w_i_prox;
    logic [32:0] w_hd_fim;
    logic [32:0] w_mem_fim;
    logic        w_rejeita;
    logic        w_vazio;

    // 33-bit sums so a wrapping base+length can never slip under the limit
    assign w_hd_fim  = {1'b0, hd_base} + {1'b0, quantidade};
    assign w_mem_fim = {1'b0, mem_base} + {1'b0, quantidade};
    assign w_rejeita = (contexto >= C_CONTEXTOS) || (w_hd_fim > C_HD_LIMITE) ||
                       (w_mem_fim > C_MEM_LIMITE);
    assign w_vazio   = (quantidade == 32'd0);
    assign w_i_prox  = r_i + 32'd1;

    assign ocupado = (r_estado == LER) || (r_estado == ESPERA) || (r_estado == ESCREVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            IDLE: begin
                if (inicio) begin
                    w_proximo = (w_rejeita || w_vazio) ? FIM : LER;
                end
            end
            LER:      w_proximo = ESPERA;
            ESPERA:   w_proximo = ESCREVER;
            ESCREVER: w_proximo = (w_i_prox == r_quantidade) ? FIM : LER;
            FIM:      w_proximo = IDLE;
            default:  w_proximo = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op             <= 1'b0;
            r_rejeitado      <= 1'b0;
            r_hd_base        <= 32'd0;
            r_mem_base       <= 32'd0;
            r_quantidade     <= 32'd0;
            r_i              <= 32'd0;
            hd_endereco      <= 32'd0;
            hd_contexto      <= 32'd0;
            hd_dado_escrita  <= 32'd0;
            hd_escrita       <= 1'b0;
            mem_endereco     <= 32'd0;
            mem_dado_escrita <= 32'd0;
            mem_escrita      <= 1'b0;
            concluido        <= 1'b0;
            erro             <= 1'b0;
        end else begin
            hd_escrita  <= 1'b0;
            mem_escrita <= 1'b0;
            // Completion is flagged on the edge that leaves FIM
            concluido   <= (r_estado == FIM);
            erro        <= (r_estado == FIM) && r_rejeitado;
            case (r_estado)
                IDLE: begin
                    if (inicio) begin
                        r_op         <= operacao;
                        r_rejeitado  <= w_rejeita;
                        r_hd_base    <= hd_base;
                        r_mem_base   <= mem_base;
                        r_quantidade <= quantidade;
                        r_i          <= 32'd0;
                        hd_contexto  <= contexto;
                        if (!w_rejeita && !w_vazio) begin
                            if (operacao) begin
                                mem_endereco <= mem_base;
                            end else begin
                                hd_endereco <= hd_base;
                            end
                        end
                    end
                end
                ESPERA: begin
                    if (r_op) begin
                        hd_dado_escrita <= mem_dado_saida;
                        hd_endereco     <= r_hd_base + r_i;
                        hd_escrita      <= 1'b1;
                    end else begin
                        mem_dado_escrita <= hd_dado_saida;
                        mem_endereco     <= r_mem_base + r_i;
                        mem_escrita      <= 1'b1;
                    end
                end
                ESCREVER: begin
                    r_i <= w_i_prox;
                    if (w_i_prox != r_quantidade) begin
                        if (r_op) begin
                            mem_endereco <= r_mem_base + w_i_prox;
                        end else begin
                            hd_endereco <= r_hd_base + w_i_prox;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_hd.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_hd
// Brief    : Directed self-checking bench for controlador_hd with simple
//            registered disk and memory models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_hd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic        operacao;
    logic [31:0] contexto;
    logic [31:0] hd_base;
    logic [31:0] mem_base;
    logic [31:0] quantidade;
    logic [31:0] hd_endereco;
    logic [31:0] hd_contexto;
    logic [31:0] hd_dado_escrita;
    logic        hd_escrita;
    logic [31:0] hd_dado_saida;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dado_escrita;
    logic        mem_escrita;
    logic [31:0] mem_dado_saida;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    controlador_hd #(
        .HD_CONTEXTOS(4),
        .HD_PALAVRAS (51),
        .MEM_PALAVRAS(256)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inicio          (inicio),
        .operacao        (operacao),
        .contexto        (contexto),
        .hd_base         (hd_base),
        .mem_base        (mem_base),
        .quantidade      (quantidade),
        .hd_endereco     (hd_endereco),
        .hd_contexto     (hd_contexto),
        .hd_dado_escrita (hd_dado_escrita),
        .hd_escrita      (hd_escrita),
        .hd_dado_saida   (hd_dado_saida),
        .mem_endereco    (mem_endereco),
        .mem_dado_escrita(mem_dado_escrita),
        .mem_escrita     (mem_escrita),
        .mem_dado_saida  (mem_dado_saida),
        .ocupado         (ocupado),
        .concluido       (concluido),
        .erro            (erro)
    );

    always #5 clk = ~clk;

    // Storage models: registered reads, writes on the enable, plus a preload port
    logic [31:0] disco [0:3][0:50];
    logic [31:0] mem   [0:255];
    logic        pl_en = 1'b0;
    logic        pl_disco = 1'b0;
    logic [1:0]  pl_ctx = 2'd0;
    logic [7:0]  pl_addr = 8'd0;
    logic [31:0] pl_dado = 32'd0;
    logic [31:0] exp_ctx = 32'd0;
    int          n_hd_wr = 0;
    int          n_mem_wr = 0;
    int          n_ambos = 0;
    int          n_ctx_ruim = 0;
    int          n_chk = 0;
    int          n_err = 0;

    wire hd_ok = (hd_contexto < 32'd4) && (hd_endereco < 32'd51);
    wire mem_ok = (mem_endereco < 32'd256);

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_disco) disco[pl_ctx][pl_addr[5:0]] <= pl_dado;
            else          mem[pl_addr] <= pl_dado;
        end
        if (hd_escrita) begin
            n_hd_wr++;
            if (hd_ok) disco[hd_contexto[1:0]][hd_endereco[5:0]] <= hd_dado_escrita;
        end
        if (mem_escrita) begin
            n_mem_wr++;
            if (mem_ok) mem[mem_endereco[7:0]] <= mem_dado_escrita;
        end
        if (hd_escrita && mem_escrita) n_ambos++;
        if (ocupado && hd_contexto != exp_ctx) n_ctx_ruim++;
        hd_dado_saida  <= hd_ok ? disco[hd_contexto[1:0]][hd_endereco[5:0]] : 32'd0;
        mem_dado_saida <= mem_ok ? mem[mem_endereco[7:0]] : 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input bit is_disco, input int ctx, input int addr, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_disco = is_disco; pl_ctx = 2'(ctx); pl_addr = 8'(addr); pl_dado = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Latency counts rising edges after the accepting edge until concluido is seen
    task automatic issue(input logic op, input logic [31:0] ctx, input logic [31:0] hb,
                         input logic [31:0] mb, input logic [31:0] q, input bit interfere,
                         output int lat, output logic err);
        @(negedge clk);
        operacao = op; contexto = ctx; hd_base = hb; mem_base = mb; quantidade = q;
        inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        lat = -1;
        err = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (interfere && n == 2) begin
                operacao = ~op; contexto = 32'd0; hd_base = 32'd5; mem_base = 32'd7;
                quantidade = 32'd1; inicio = 1'b1;
            end
            if (interfere && n == 4) inicio = 1'b0;
            if (concluido) begin
                lat = n;
                err = erro;
                break;
            end
        end
    endtask

    int   lat;
    logic err;
    int   hd0, mem0, ctx0;

    initial begin
        rst_n = 1'b0; inicio = 1'b0; operacao = 1'b0; contexto = 32'd0;
        hd_base = 32'd0; mem_base = 32'd0; quantidade = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_concluido", 32'(concluido), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_hd_escrita", 32'(hd_escrita), 32'd0);
        chk("rst_mem_escrita", 32'(mem_escrita), 32'd0);
        chk("rst_hd_endereco", hd_endereco, 32'd0);
        chk("rst_mem_endereco", mem_endereco, 32'd0);
        rst_n = 1'b1;

        // Load: disk ctx 2 [10..13] -> mem [100..103]
        for (int k = 0; k < 4; k++) poke(1'b1, 2, 10 + k, 32'hA0 + 32'(k));
        exp_ctx = 32'd2; hd0 = n_hd_wr; mem0 = n_mem_wr; ctx0 = n_ctx_ruim;
        issue(1'b0, 32'd2, 32'd10, 32'd100, 32'd4, 1'b0, lat, err);
        chk("load_latency", 32'(lat), 32'd13);
        chk("load_erro", 32'(err), 32'd0);
        @(posedge clk); #1;
        chk("load_concluido_pulse", 32'(concluido), 32'd0);
        for (int k = 0; k < 4; k++) chk("load_mem_word", mem[100 + k], 32'hA0 + 32'(k));
        chk("load_mem_writes", 32'(n_mem_wr - mem0), 32'd4);
        chk("load_hd_writes", 32'(n_hd_wr - hd0), 32'd0);
        chk("load_ctx", 32'(n_ctx_ruim - ctx0), 32'd0);

        // Store: mem [20..22] -> disk ctx 1 [48..50] (ends exactly at the last word)
        poke(1'b0, 0, 20, 32'h11); poke(1'b0, 0, 21, 32'h22); poke(1'b0, 0, 22, 32'h33);
        exp_ctx = 32'd1; hd0 = n_hd_wr; mem0 = n_mem_wr; ctx0 = n_ctx_ruim;
        issue(1'b1, 32'd1, 32'd48, 32'd20, 32'd3, 1'b0, lat, err);
        chk("store_latency", 32'(lat), 32'd10);
        chk("store_erro", 32'(err), 32'd0);
        chk("store_disk48", disco[1][48], 32'h11);
        chk("store_disk49", disco[1][49], 32'h22);
        chk("store_disk50", disco[1][50], 32'h33);
        chk("store_hd_writes", 32'(n_hd_wr - hd0), 32'd3);
        chk("store_mem_writes", 32'(n_mem_wr - mem0), 32'd0);
        chk("store_ctx", 32'(n_ctx_ruim - ctx0), 32'd0);
        chk("store_hd_contexto", hd_contexto, 32'd1);

        // Rejects: disk overrun, bad context, 33-bit wrap
        hd0 = n_hd_wr; mem0 = n_mem_wr;
        issue(1'b1, 32'd0, 32'd49, 32'd0, 32'd3, 1'b0, lat, err);
        chk("rej_range_latency", 32'(lat), 32'd1);
        chk("rej_range_erro", 32'(err), 32'd1);
        issue(1'b0, 32'd4, 32'd0, 32'd0, 32'd1, 1'b0, lat, err);
        chk("rej_ctx_latency", 32'(lat), 32'd1);
        chk("rej_ctx_erro", 32'(err), 32'd1);
        issue(1'b0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd2, 1'b0, lat, err);
        chk("rej_wrap_latency", 32'(lat), 32'd1);
        chk("rej_wrap_erro", 32'(err), 32'd1);
        @(posedge clk); #1;
        chk("rej_erro_pulse", 32'(erro), 32'd0);
        chk("rej_writes", 32'(n_hd_wr - hd0 + n_mem_wr - mem0), 32'd0);

        // Zero length
        hd0 = n_hd_wr; mem0 = n_mem_wr;
        issue(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, lat, err);
        chk("zero_latency", 32'(lat), 32'd1);
        chk("zero_erro", 32'(err), 32'd0);
        chk("zero_writes", 32'(n_hd_wr - hd0 + n_mem_wr - mem0), 32'd0);

        // Start while busy must be ignored
        for (int k = 0; k < 4; k++) poke(1'b1, 3, k, 32'hB0 + 32'(k));
        exp_ctx = 32'd3; hd0 = n_hd_wr; mem0 = n_mem_wr; ctx0 = n_ctx_ruim;
        issue(1'b0, 32'd3, 32'd0, 32'd200, 32'd4, 1'b1, lat, err);
        chk("busy_latency", 32'(lat), 32'd13);
        chk("busy_erro", 32'(err), 32'd0);
        for (int k = 0; k < 4; k++) chk("busy_mem_word", mem[200 + k], 32'hB0 + 32'(k));
        chk("busy_mem_writes", 32'(n_mem_wr - mem0), 32'd4);
        chk("busy_hd_writes", 32'(n_hd_wr - hd0), 32'd0);
        chk("busy_ctx", 32'(n_ctx_ruim - ctx0), 32'd0);
        repeat (2) @(posedge clk); #1;
        chk("busy_idle_after", 32'(ocupado), 32'd0);

        // Reset during ESCREVER of word 2 of a 4-word load
        for (int k = 0; k < 4; k++) poke(1'b1, 0, 20 + k, 32'hC0 + 32'(k));
        poke(1'b0, 0, 52, 32'd0); poke(1'b0, 0, 53, 32'd0);
        exp_ctx = 32'd0; mem0 = n_mem_wr; hd0 = n_hd_wr;
        @(negedge clk);
        operacao = 1'b0; contexto = 32'd0; hd_base = 32'd20; mem_base = 32'd50;
        quantidade = 32'd4; inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("rstmid_in_escrever", 32'(mem_escrita), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_escrita", 32'(mem_escrita), 32'd0);
        chk("rstmid_hd_escrita", 32'(hd_escrita), 32'd0);
        chk("rstmid_ocupado", 32'(ocupado), 32'd0);
        repeat (2) @(negedge clk);
        chk("rstmid_mem50", mem[50], 32'hC0);
        chk("rstmid_mem51", mem[51], 32'hC1);
        chk("rstmid_mem52", mem[52], 32'd0);
        chk("rstmid_mem53", mem[53], 32'd0);
        chk("rstmid_writes", 32'(n_mem_wr - mem0 + n_hd_wr - hd0), 32'd2);
        rst_n = 1'b1;

        // Engine accepts a fresh command after reset release
        poke(1'b1, 0, 30, 32'hD0);
        issue(1'b0, 32'd0, 32'd30, 32'd60, 32'd1, 1'b0, lat, err);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_mem60", mem[60], 32'hD0);
        chk("never_both_writes", 32'(n_ambos), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
